// File: rtl/sram_arbiter_2p.sv
// Purpose: share one single-port 32x1024 SRAM wrapper between the fetch port and the load/store port.
// Latency: grant is combinational in the request cycle; the response appears exactly one cycle after the grant.
// Backpressure: a requester holds its req until it sees gnt. Data wins ties, and fetch is forced after STARVE_MAX data grants.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   i_req/i_addr/i_flush      fetch request, word address, response discard
//   i_gnt/i_rvalid/i_rdata    fetch grant, response pulse, held read data
//   d_req/d_we/d_be/d_addr/d_wdata   load/store request fields
//   d_gnt/d_rvalid/d_rdata    data grant, response pulse (read or write ack), held read data
//   sram_cs/we/be/addr/din    drive to the SRAM wrapper
//   sram_dout                 wrapper read data, valid the cycle after a read issue
module sram_arbiter_2p #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              sram_cs,
    output logic              sram_we,
    output logic [3:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_din,
    input  logic [31:0]       sram_dout
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  starve_cnt;
    logic              force_i;
    logic              any_gnt;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;

    logic              rsp_v;
    logic              rsp_port;   // 0 = fetch, 1 = data
    logic              rsp_wr;

    logic              d_rd_rsp;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    // Grants are gated by rst so nothing reaches the SRAM while in reset.
    assign force_i = i_req & (starve_cnt == CNT_MAX);
    assign d_gnt   = ~rst & d_req & ~force_i;
    assign i_gnt   = ~rst & i_req & (~d_req | force_i);
    assign any_gnt = i_gnt | d_gnt;

    // Counts consecutive data grants that happened while a fetch was waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // SRAM drive
    // ------------------------------------------------------------------
    // Address and write data hold their last granted values on idle cycles
    // so the wrapper pins do not toggle. A fetch has no write data, so
    // sram_din keeps the last data-port value on fetch grants.
    assign sram_cs   = any_gnt;
    assign sram_we   = d_gnt & d_we;
    assign sram_be   = d_gnt ? d_be : 4'b0000;
    assign sram_addr = rst   ? '0 :
                       i_gnt ? i_addr :
                       d_gnt ? d_addr : addr_q;
    assign sram_din  = rst   ? 32'h0 :
                       d_gnt ? d_wdata : din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            din_q  <= 32'h0;
        end else begin
            if (any_gnt) begin
                addr_q <= sram_addr;
            end
            if (d_gnt) begin
                din_q <= d_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response tracking
    // ------------------------------------------------------------------
    // A fetch flushed in its own grant cycle never becomes a valid response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_v    <= 1'b0;
            rsp_port <= 1'b0;
            rsp_wr   <= 1'b0;
        end else begin
            rsp_v    <= d_gnt | (i_gnt & ~i_flush);
            rsp_port <= d_gnt;
            rsp_wr   <= d_gnt & d_we;
        end
    end

    // A flush in the response cycle also kills the fetch response. rst masks
    // any response that was in flight when reset arrived.
    assign i_rvalid = ~rst & rsp_v & ~rsp_port & ~i_flush;
    assign d_rvalid = ~rst & rsp_v &  rsp_port;
    assign d_rd_rsp = d_rvalid & ~rsp_wr;

    // Read data is presented in the rvalid cycle straight from the wrapper;
    // the hold registers keep it stable until that port's next read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            if (i_rvalid) begin
                i_rdata_q <= sram_dout;
            end
            if (d_rd_rsp) begin
                d_rdata_q <= sram_dout;
            end
        end
    end

    assign i_rdata = rst      ? 32'h0 :
                     i_rvalid ? sram_dout : i_rdata_q;
    assign d_rdata = rst      ? 32'h0 :
                     d_rd_rsp ? sram_dout : d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
module tb_sram_arbiter_2p;

    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_flush;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              sram_cs;
    logic              sram_we;
    logic [3:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_din;
    logic [31:0]       sram_dout;

    sram_arbiter_2p #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_be   (sram_be),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM wrapper: one-cycle read latency, byte-enabled writes.
    logic [31:0] sram_mem [DEPTH];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model state (transaction level)
    // ------------------------------------------------------------------
    logic [31:0]       ref_mem [DEPTH];
    int                streak;          // data grants since the waiting fetch began waiting
    bit                pend_v;
    bit                pend_data_port;
    bit                pend_wr;
    logic [31:0]       pend_data;
    logic [31:0]       i_hold, d_hold;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       last_din;
    bit                last_i_gnt, last_d_gnt;

    int n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check mid-cycle, then
    // advance the model across the rising edge.
    task automatic step();
        bit          e_force, e_i, e_d, e_irv, e_drv;
        logic [31:0] e_irdata, e_drdata;
        logic [ADDR_W-1:0] e_addr;
        logic [31:0] e_din;
        #4;
        e_force = i_req && (streak == STARVE_MAX);
        e_d     = !rst && d_req && !e_force;
        e_i     = !rst && i_req && (!d_req || e_force);
        e_irv   = !rst && pend_v && !pend_data_port && !i_flush;
        e_drv   = !rst && pend_v && pend_data_port;
        e_irdata = rst ? 32'h0 : (e_irv ? pend_data : i_hold);
        e_drdata = rst ? 32'h0 : ((e_drv && !pend_wr) ? pend_data : d_hold);
        e_addr   = rst ? '0 : (e_i ? i_addr : (e_d ? d_addr : last_addr));
        e_din    = rst ? 32'h0 : (e_d ? d_wdata : last_din);

        check("i_gnt",     i_gnt,     e_i);
        check("d_gnt",     d_gnt,     e_d);
        check("sram_cs",   sram_cs,   e_i || e_d);
        check("sram_we",   sram_we,   e_d && d_we);
        check("sram_be",   sram_be,   e_d ? d_be : 4'b0);
        check("sram_addr", sram_addr, e_addr);
        check("sram_din",  sram_din,  e_din);
        check("i_rvalid",  i_rvalid,  e_irv);
        check("d_rvalid",  d_rvalid,  e_drv);
        check("i_rdata",   i_rdata,   e_irdata);
        check("d_rdata",   d_rdata,   e_drdata);

        @(posedge clk);
        last_i_gnt = e_i;
        last_d_gnt = e_d;
        if (rst) begin
            streak = 0; pend_v = 0; i_hold = 0; d_hold = 0;
            last_addr = '0; last_din = 0;
        end else begin
            i_hold = e_irdata;
            d_hold = e_drdata;
            last_addr = e_addr;
            last_din  = e_din;
            pend_v = 0;
            if (e_d) begin
                pend_v = 1; pend_data_port = 1; pend_wr = d_we;
                pend_data = ref_mem[d_addr];
                if (d_we)
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
            end else if (e_i) begin
                pend_v = !i_flush; pend_data_port = 0; pend_wr = 0;
                pend_data = ref_mem[i_addr];
            end
            if (!i_req || e_i) streak = 0;
            else if (e_d && streak < STARVE_MAX) streak++;
        end
        #1;
    endtask

    // Random requester behaviour: a request stays up with the same fields
    // until granted, then a fresh one may follow.
    task automatic drive_rand();
        if (last_i_gnt || !i_req) begin
            i_req  = ($urandom_range(0, 3) != 0);
            i_addr = ADDR_W'($urandom);
        end
        if (last_d_gnt || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_be    = 4'($urandom);
            d_addr  = ADDR_W'($urandom_range(0, 15)); // small window to revisit addresses
            d_wdata = $urandom;
        end
        i_flush = ($urandom_range(0, 7) == 0);
        rst     = ($urandom_range(0, 63) == 0);
    endtask

    initial begin
        logic [31:0] v;
        n_cmp = 0; n_bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            v = $urandom;
            sram_mem[a] = v;
            ref_mem[a]  = v;
        end
        sram_mem[10'h3FF] = 32'h11223344;
        ref_mem[10'h3FF]  = 32'h11223344;
        sram_dout = 32'h0;
        streak = 0; pend_v = 0; pend_data_port = 0; pend_wr = 0; pend_data = 0;
        i_hold = 0; d_hold = 0; last_addr = '0; last_din = 0;
        last_i_gnt = 0; last_d_gnt = 0;

        // Reset with both requests high
        rst = 1; i_req = 1; i_addr = 10'h055; i_flush = 0;
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 10'h020; d_wdata = 32'h0;
        step(); step();
        rst = 0;
        #1 check("first_gnt_is_data", d_gnt, 1'b1);
        step();
        d_req = 0;
        step();                       // fetch gets its turn
        i_req = 0;
        step();

        // Fetch read of 0x010
        i_req = 1; i_addr = 10'h010;
        #1 check("fetch_gnt_addr", sram_addr, 32'h010);
        step();
        i_req = 0;
        #1 check("fetch_rdata", i_rdata, ref_mem[10'h010]);
        step();
        step();                       // hold checked by the model

        // Byte-enabled write then read back of 0x3FF
        d_req = 1; d_we = 1; d_be = 4'b0101; d_addr = 10'h3FF; d_wdata = 32'hAABBCCDD;
        step();
        d_req = 0;
        #1 check("wr_ack", d_rvalid, 1'b1);
        step();
        d_req = 1; d_we = 0;
        step();
        d_req = 0;
        #1 check("wr_rd_merge", d_rdata, 32'h11BB33DD);
        step();

        // Starvation bound: D,D,D,D,I repeating
        i_req = 1; d_req = 1; d_we = 0;
        for (int k = 0; k < 20; k++) begin
            #1 check("starve_pat", i_gnt, (k % 5) == 4);
            step();
            if (last_i_gnt) i_addr = ADDR_W'($urandom);
            if (last_d_gnt) d_addr = ADDR_W'($urandom);
        end
        i_req = 0; d_req = 0;
        step(); step();

        // Flush in the response cycle, data grant alongside
        i_req = 1; i_addr = 10'h010;
        step();
        i_req = 0; i_flush = 1; d_req = 1; d_we = 0; d_addr = 10'h3FF;
        #1 check("flush_no_rvalid", i_rvalid, 1'b0);
        step();
        i_flush = 0; d_req = 0;
        #1 check("data_after_flush", d_rdata, 32'h11BB33DD);
        step();

        // Reset while a data read is in flight
        d_req = 1; d_we = 0; d_addr = 10'h010;
        step();
        d_req = 0; rst = 1;
        #1 check("rst_kill_rvalid", d_rvalid, 1'b0);
        step();
        rst = 0;
        #1 check("rst_starve_cnt", 32'(dut.starve_cnt), 32'h0);
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_rand();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
